// File: rtl/bus_demux16_pkg.sv
// Shared types and constants for the 16-slot bus demultiplexer.
// Holds the FSM state encoding, slot geometry and the default access timeout.
package bus_demux16_pkg;

  localparam int unsigned NumSlots       = 16;
  localparam int unsigned SelW           = 4;
  localparam int unsigned DefaultTimeout = 15;
  // Wide enough for the largest permitted timeout of 255.
  localparam int unsigned CntW           = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

endpackage

// File: rtl/bus_demux16_if.sv
// Request/response bundle between an initiator and the demux, plus the fan-out
// towards the 16 targets (chip selects, qualifiers, latched address/data, acks).
interface bus_demux16_if
  import bus_demux16_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 32
);

  logic [AW-1:0]       addr;
  logic [WIDTH-1:0]    wdata;
  logic                wen;
  logic                ren;
  logic [NumSlots-1:0] ack_i;
  logic [NumSlots-1:0] cs;
  logic                wr_o;
  logic                rd_o;
  logic [AW-1:0]       addr_o;
  logic [WIDTH-1:0]    wdata_o;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output addr, wdata, wen, ren, ack_i,
    input  cs, wr_o, rd_o, addr_o, wdata_o, busy, done, err
  );

  modport slave (
    input  addr, wdata, wen, ren, ack_i,
    output cs, wr_o, rd_o, addr_o, wdata_o, busy, done, err
  );

endinterface

// File: rtl/bus_demux16_dec4to16.sv
// Combinational 4-to-16 one-hot decoder used to form the slot chip selects.
module dec4to16
  import bus_demux16_pkg::*;
(
  input  logic [SelW-1:0]     sel_i,
  output logic [NumSlots-1:0] onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/bus_demux16.sv
// Single-outstanding bus demultiplexer: routes one request to one of 16 slots,
// waits for that slot's ack or a timeout, then pulses done (and err on timeout).
module bus_demux16
  import bus_demux16_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input logic          clk,
  input logic          reset,
  bus_demux16_if.slave bus
);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [SelW-1:0]     sel_q, sel_d;
  logic [NumSlots-1:0] cs_q, cs_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;

  logic [SelW-1:0]     req_sel;
  logic [NumSlots-1:0] req_onehot;
  logic                ack_sel;
  logic                last_cycle;

  assign req_sel = bus.addr[AW-1 -: SelW];

  dec4to16 u_dec (
    .sel_i    (req_sel),
    .onehot_o (req_onehot)
  );

  // Only the latched slot's ack counts; the other 15 are ignored.
  assign ack_sel    = bus.ack_i[sel_q];
  assign last_cycle = (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    cs_d    = cs_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.wen || bus.ren) begin
          state_d = StAccess;
          cnt_d   = '0;
          sel_d   = req_sel;
          cs_d    = req_onehot;
          // Simultaneous wen/ren resolves to a write.
          wr_d    = bus.wen;
          rd_d    = bus.ren & ~bus.wen;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
        end
      end
      StAccess: begin
        // Ack on the final permitted cycle still wins over the timeout.
        if (ack_sel || last_cycle) begin
          state_d = StDone;
          cs_d    = '0;
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = ~ack_sel;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= '0;
      cs_q    <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.cs      = cs_q;
  assign bus.wr_o    = wr_q;
  assign bus.rd_o    = rd_q;
  assign bus.addr_o  = addr_q;
  assign bus.wdata_o = wdata_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bus_demux16.sv
// Randomised bench for bus_demux16: a transaction-level model predicts, per cycle,
// when cs/done/err must appear from the planned ack delay of each request.
module tb_bus_demux16;
  import bus_demux16_pkg::*;

  localparam int unsigned TO  = 15;
  localparam int          BIG = 1 << 30;

  logic clk = 1'b0;
  logic reset;
  int   cyc    = 0;
  int   total  = 0;
  int   bad    = 0;
  int   n_req  = 0;
  int   n_done = 0;

  // Model of the transaction in flight: accepted at edge m_acc, cs high m_len cycles.
  int          m_acc = BIG;
  int          m_len = 0;
  logic [3:0]  m_slot = 4'd0;
  logic        m_wr = 1'b0, m_rd = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = 32'd0, m_prev_addr = 32'd0;
  logic [31:0] m_wdata = 32'd0, m_prev_wdata = 32'd0;

  bus_demux16_if #(.WIDTH(32), .AW(32)) bus ();

  bus_demux16 #(.WIDTH(32), .AW(32), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] stray_bits(input logic [3:0] s, input int mode);
    logic [15:0] v;
    v    = (mode == 2) ? 16'hFFFF : ((mode == 1) ? 16'($urandom) : 16'h0000);
    v[s] = 1'b0;
    return v;
  endfunction

  always @(negedge clk) begin : cmp
    logic        in_acc, in_done;
    logic [15:0] e_cs;
    in_acc  = (cyc >= m_acc) && (cyc < m_acc + m_len);
    in_done = (cyc == m_acc + m_len);
    e_cs    = in_acc ? (16'h0001 << m_slot) : 16'h0000;
    chk("cs", 64'(bus.cs), 64'(e_cs));
    chk("cs_onehot0", 64'($onehot0(bus.cs)), 64'd1);
    chk("wr_o", 64'(bus.wr_o), 64'(in_acc & m_wr));
    chk("rd_o", 64'(bus.rd_o), 64'(in_acc & m_rd));
    chk("busy", 64'(bus.busy), 64'(in_acc | in_done));
    chk("done", 64'(bus.done), 64'(in_done));
    chk("err", 64'(bus.err), 64'(in_done & m_err));
    chk("addr_o", 64'(bus.addr_o), 64'((cyc >= m_acc) ? m_addr : m_prev_addr));
    chk("wdata_o", 64'(bus.wdata_o), 64'((cyc >= m_acc) ? m_wdata : m_prev_wdata));
    if (bus.done === 1'b1) n_done++;
  end

  // Entered just after an edge with the DUT idle; returns just after the edge
  // that brings it back to idle.
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic w,
                     input logic r, input int d, input int stray, input bit junk,
                     output int cs_cnt, output logic [15:0] first_cs, output logic first_wr,
                     output logic first_rd, output logic got_done, output logic got_err);
    int         acc, len;
    logic [3:0] s;
    s   = a[31:28];
    acc = cyc + 1;
    len = (d < int'(TO)) ? d + 1 : int'(TO);
    m_prev_addr  = m_addr;
    m_prev_wdata = m_wdata;
    m_addr  = a;
    m_wdata = wd;
    m_slot  = s;
    m_wr    = w;
    m_rd    = r & ~w;
    m_err   = (d >= int'(TO));
    m_len   = len;
    m_acc   = acc;
    n_req++;
    bus.addr  = a;
    bus.wdata = wd;
    bus.wen   = w;
    bus.ren   = r;
    bus.ack_i = stray_bits(s, stray);
    cs_cnt = 0; first_cs = '0; first_wr = 1'b0; first_rd = 1'b0;
    got_done = 1'b0; got_err = 1'b0;
    for (int c = acc; c <= acc + len; c++) begin
      @(posedge clk); #2;
      if (bus.cs != 16'h0000) cs_cnt++;
      if (c == acc) begin
        first_cs = bus.cs; first_wr = bus.wr_o; first_rd = bus.rd_o;
      end
      if (c == acc + len) begin
        got_done = bus.done; got_err = bus.err;
      end
      if (junk && $urandom_range(2) == 0) begin
        bus.wen   = 1'($urandom_range(1));
        bus.ren   = 1'($urandom_range(1));
        bus.addr  = $urandom;
        bus.wdata = $urandom;
      end else begin
        bus.wen = 1'b0;
        bus.ren = 1'b0;
      end
      bus.ack_i = stray_bits(s, stray);
      if (c - acc == d) bus.ack_i[s] = 1'b1;
    end
    @(posedge clk); #2;
    bus.wen   = 1'b0;
    bus.ren   = 1'b0;
    bus.ack_i = '0;
  endtask

  initial begin
    int          n, d, op;
    logic [15:0] fcs;
    logic        fw, fr, gd, ge;
    logic [3:0]  slot;
    reset     = 1'b1;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.wen   = 1'b0;
    bus.ren   = 1'b0;
    bus.ack_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cs", 64'(bus.cs), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    #1;
    reset = 1'b0;

    // Write to slot 3 on the first edge after reset, acked in the 2nd ACCESS cycle.
    txn(32'h3000_0010, 32'hDEADBEEF, 1'b1, 1'b0, 1, 0, 1'b0, n, fcs, fw, fr, gd, ge);
    chk("wr_cs", 64'(fcs), 64'h0008);
    chk("wr_cs_cycles", 64'(n), 64'd2);
    chk("wr_wr_o", 64'(fw), 64'd1);
    chk("wr_rd_o", 64'(fr), 64'd0);
    chk("wr_done", 64'(gd), 64'd1);
    chk("wr_err", 64'(ge), 64'd0);
    chk("wr_wdata_hold", 64'(bus.wdata_o), 64'hDEADBEEF);

    // Read to slot 15 with no ack: times out after exactly 15 cycles.
    txn(32'hF000_0004, 32'h0, 1'b0, 1'b1, 40, 1, 1'b0, n, fcs, fw, fr, gd, ge);
    chk("to_cs", 64'(fcs), 64'h8000);
    chk("to_cs_cycles", 64'(n), 64'd15);
    chk("to_rd_o", 64'(fr), 64'd1);
    chk("to_done", 64'(gd), 64'd1);
    chk("to_err", 64'(ge), 64'd1);
    chk("to_busy_after", 64'(bus.busy), 64'd0);

    // Read to slot 2 with every other slot acking throughout.
    txn(32'h2000_0000, 32'h0, 1'b0, 1'b1, 4, 2, 1'b0, n, fcs, fw, fr, gd, ge);
    chk("stray_cs", 64'(fcs), 64'h0004);
    chk("stray_cs_cycles", 64'(n), 64'd5);
    chk("stray_done", 64'(gd), 64'd1);
    chk("stray_err", 64'(ge), 64'd0);

    // wen and ren together, with junk requests while busy.
    txn(32'h7000_0000, 32'h0000_1234, 1'b1, 1'b1, 0, 1, 1'b1, n, fcs, fw, fr, gd, ge);
    chk("both_wr_o", 64'(fw), 64'd1);
    chk("both_rd_o", 64'(fr), 64'd0);
    chk("both_cs_cycles", 64'(n), 64'd1);

    // Ack on the 15th (final) ACCESS cycle beats the timeout.
    txn(32'hA000_0000, 32'h5A5A_5A5A, 1'b1, 1'b0, 14, 1, 1'b1, n, fcs, fw, fr, gd, ge);
    chk("last_cs_cycles", 64'(n), 64'd15);
    chk("last_done", 64'(gd), 64'd1);
    chk("last_err", 64'(ge), 64'd0);

    // Reset during the 3rd ACCESS cycle of a slot-5 read.
    m_prev_addr  = m_addr;
    m_prev_wdata = m_wdata;
    m_addr  = 32'h5000_0000;
    m_wdata = 32'h0000_0055;
    m_slot  = 4'd5;
    m_wr    = 1'b0;
    m_rd    = 1'b1;
    m_err   = 1'b1;
    m_len   = int'(TO);
    m_acc   = cyc + 1;
    bus.addr  = 32'h5000_0000;
    bus.wdata = 32'h0000_0055;
    bus.ren   = 1'b1;
    @(posedge clk); #2;
    bus.ren = 1'b0;
    repeat (2) begin
      @(posedge clk); #2;
    end
    chk("rst_pre_cs", 64'(bus.cs), 64'h0020);
    reset = 1'b1;
    m_acc = BIG;
    m_addr = '0; m_prev_addr = '0; m_wdata = '0; m_prev_wdata = '0;
    #1;
    chk("rst_cs", 64'(bus.cs), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_addr_o", 64'(bus.addr_o), 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    txn(32'h6000_0100, 32'hCAFE_F00D, 1'b1, 1'b0, 2, 1, 1'b0, n, fcs, fw, fr, gd, ge);
    chk("post_rst_cs", 64'(fcs), 64'h0040);
    chk("post_rst_done", 64'(gd), 64'd1);
    chk("post_rst_err", 64'(ge), 64'd0);

    // Random sweep over all slots, ack delays 0..20.
    for (int i = 0; i < 48; i++) begin
      slot = (i < 16) ? 4'(i) : 4'($urandom_range(15));
      d    = int'($urandom_range(20));
      op   = int'($urandom_range(2));
      repeat ($urandom_range(2)) begin
        @(posedge clk); #2;
      end
      txn({slot, 28'($urandom)}, $urandom, (op != 1), (op != 0), d, 1, 1'b1,
          n, fcs, fw, fr, gd, ge);
      chk("sweep_cs_cycles", 64'(n), 64'((d < int'(TO)) ? d + 1 : int'(TO)));
    end

    chk("done_count", 64'(n_done), 64'(n_req));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_demux16.md
BUS_DEMUX16 -- requirements
Module: bus_demux16

Interface
REQ-001 Parameter WIDTH, default 32: data width of wdata and wdata_o.
REQ-002 Parameter AW, default 32: address width; sel = addr[AW-1:AW-4].
REQ-003 Parameter TIMEOUT, default 15, range 1..255: maximum number of ACCESS cycles without ack.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 addr  in  AW  request address; the top 4 bits select the slot.
REQ-007 wdata  in  WIDTH  write data.
REQ-008 wen  in  1  write request strobe.
REQ-009 ren  in  1  read request strobe.
REQ-010 ack_i  in  16  per-slot acknowledge from targets.
REQ-011 cs  out  16  one-hot registered chip selects.
REQ-012 wr_o, rd_o  out  1 each  registered write and read qualifiers to the targets.
REQ-013 addr_o  out  AW  latched request address.
REQ-014 wdata_o  out  WIDTH  latched write data.
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 done  out  1  one-cycle pulse marking transaction completion.
REQ-017 err  out  1  one-cycle pulse, coincident with done, marking a timeout.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-019 In IDLE with wen|ren high in cycle N, the block SHALL latch sel, addr and wdata and enter ACCESS; cs[sel] and wr_o/rd_o SHALL be high from cycle N+1.
REQ-020 If wen and ren are high together, the request SHALL be treated as a write; rd_o SHALL stay low.
REQ-021 Requests arriving while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-022 In ACCESS, only ack_i[sel] SHALL be honoured; acks from the other 15 slots SHALL be ignored.
REQ-023 When ack_i[sel] is high in ACCESS cycle M, the block SHALL enter DONE; in cycle M+1, done = 1, err = 0, and cs, wr_o and rd_o = 0.
REQ-024 A cycle counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle without ack.
REQ-025 On the TIMEOUT-th ACCESS cycle without ack, the block SHALL enter DONE with done = 1 and err = 1.
REQ-026 cs SHALL therefore be high for at most TIMEOUT cycles per transaction.
REQ-027 If ack arrives on the final permitted cycle, ack SHALL win and err SHALL be 0.
REQ-028 DONE SHALL last exactly one cycle and then return to IDLE; the minimum request-to-next-accept spacing is 3 cycles.
REQ-029 cs SHALL be all-zero or exactly one-hot in every cycle.
REQ-030 addr_o and wdata_o SHALL hold their latched values until the next accepted request.

Reset
REQ-031 While reset = 1, asynchronously: state = IDLE, counter = 0, cs = 0, wr_o = rd_o = 0, busy = done = err = 0, addr_o = 0, wdata_o = 0.
REQ-032 Reset asserted mid-ACCESS SHALL abort the transaction with no done or err pulse.
REQ-033 The first request SHALL be accepted in the first clock edge after reset deasserts.

Structure
REQ-034 A shared package SHALL hold: the state enum (IDLE, ACCESS, DONE), the slot-count constant 16, the slot-select width 4, and the default TIMEOUT.
REQ-035 One combinational sub-module, dec4to16, SHALL convert sel into a one-hot vector; the parent SHALL register its output into cs.
REQ-036 Total RTL size SHALL be 120-400 lines.

Verification
REQ-037 Write: addr=0x3000_0010, wdata=0xDEADBEEF, wen for 1 cycle; ack_i[3] two cycles later -> cs=0x0008 for 2 cycles, wr_o=1, wdata_o=0xDEADBEEF, then done=1, err=0.
REQ-038 Timeout: read to slot 0xF, no ack, TIMEOUT=15 -> cs=0x8000 for exactly 15 cycles, then done=1, err=1, then busy=0.
REQ-039 Stray ack: read to slot 2 with ack_i[5] pulsed -> ignored; ack_i[2] later -> done=1, err=0.
REQ-040 Boundaries: wen and ren both high -> wr_o=1, rd_o=0; second request during busy -> no effect; ack on the 15th cycle -> err=0.
REQ-041 Reset mid-transaction: reset at the 3rd ACCESS cycle -> cs=0, busy=0 immediately, no done pulse; a request after release completes normally.
REQ-042 Random sweep: all 16 slots, random ack delays 0..20 -> cs is one-hot or zero in every cycle, and exactly one done per accepted request.
